io_port: RTL and testbench

- Memory-mapped I/O unit on the shared 16-bit datapath bus.
- Consumes the control unit's io_oe/io_we strobes and the address held in the AM register.
- Buffers words between the CPU and an external byte/word device through a TX FIFO and an RX FIFO, with valid/ready handshakes on the device side.
- Presents a data register (address 0) and a status register (address 1) to the CPU.

---
 rtl/io_pkg.sv | 16 +
 rtl/io_fifo.sv | 51 +++++
 rtl/io_port.sv | 128 ++++++++++++
 tb/tb_io_port.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O port: register addresses,
// status bit positions and count field offsets.
package io_pkg;

  localparam int IO_DATA   = 0;
  localparam int IO_STATUS = 1;

  localparam int ST_RXNE   = 0;
  localparam int ST_TXFULL = 1;
  localparam int ST_TXOVF  = 2;
  localparam int ST_RXUDF  = 3;

  localparam int ST_RXCNT_LSB = 8;
  localparam int ST_TXCNT_LSB = 12;

endpackage

// File: rtl/io_fifo.sv
// Generic synchronous FIFO; head is combinational (zero when empty), push/pop take effect next cycle.
// A push is accepted when full only if a pop happens in the same cycle; pop on empty is ignored.
module io_fifo #(
  parameter int word_width = 16,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [word_width-1:0]         push_data,
  input  logic                          pop,
  output logic [word_width-1:0]         head,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;

  logic [word_width-1:0] mem [fifo_depth];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(fifo_depth));
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(depth) bits, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/io_port.sv
// Memory-mapped DATA/STATUS port buffering words to/from a device via TX/RX FIFOs; device side is valid/ready.
// CPU write shows on dev_tx_valid next cycle; full TX drops words (tx_ovf), empty RX reads 0 (rx_udf); IO_PORT_IRQ_EN adds io_irq.
module io_port
  import io_pkg::*;
#(
  parameter int word_width = 16,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] io_addr,
  input  logic                  io_oe,
  input  logic                  io_we,
  input  logic [word_width-1:0] bus_in,
  output logic [word_width-1:0] bus_out,
  output logic [word_width-1:0] dev_tx_data,
  output logic                  dev_tx_valid,
  input  logic                  dev_tx_ready,
  input  logic [word_width-1:0] dev_rx_data,
  input  logic                  dev_rx_valid,
  output logic                  dev_rx_ready
`ifdef IO_PORT_IRQ_EN
  ,
  output logic                  io_irq
`endif
);

  localparam int CW = $clog2(fifo_depth) + 1;

  logic [word_width-1:0] tx_head;
  logic [word_width-1:0] rx_head;
  logic [word_width-1:0] rd_hold;
  logic [word_width-1:0] status;
  logic [CW-1:0]         tx_count;
  logic [CW-1:0]         rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic is_status, wr_data, wr_status, rd_pulse, rd_data;
  logic oe_q, hold_vld, tx_ovf, rx_udf;
  logic unused_addr;

  assign unused_addr = ^io_addr[word_width-1:1];

  assign is_status = (io_addr[0] == 1'(IO_STATUS));
  assign wr_data   = io_we & !is_status;
  assign wr_status = io_we & is_status;
  assign rd_pulse  = io_oe & !oe_q & !io_we;
  assign rd_data   = rd_pulse & !is_status;

  assign tx_pop  = dev_tx_valid & dev_tx_ready;
  assign tx_push = wr_data & (!tx_full | tx_pop);
  assign rx_push = dev_rx_valid & dev_rx_ready;
  assign rx_pop  = rd_data & !rx_empty;

  assign dev_tx_valid = !tx_empty;
  assign dev_tx_data  = tx_head;
  assign dev_rx_ready = !rx_full & !rst;

  io_fifo #(.word_width(word_width), .fifo_depth(fifo_depth)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (bus_in),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  io_fifo #(.word_width(word_width), .fifo_depth(fifo_depth)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (dev_rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // The popped word is held so a multi-cycle read keeps showing the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q     <= 1'b0;
      hold_vld <= 1'b0;
      rd_hold  <= '0;
      tx_ovf   <= 1'b0;
      rx_udf   <= 1'b0;
    end else begin
      oe_q     <= io_oe;
      hold_vld <= io_oe & (hold_vld | rd_data);
      if (rd_data) rd_hold <= rx_head;
      if (wr_data && tx_full && !tx_pop)       tx_ovf <= 1'b1;
      else if (wr_status && bus_in[ST_TXOVF])  tx_ovf <= 1'b0;
      if (rd_data && rx_empty)                 rx_udf <= 1'b1;
      else if (wr_status && bus_in[ST_RXUDF])  rx_udf <= 1'b0;
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_RXNE]                = !rx_empty;
    status[ST_TXFULL]              = tx_full;
    status[ST_TXOVF]               = tx_ovf;
    status[ST_RXUDF]               = rx_udf;
    status[ST_RXCNT_LSB +: 4]      = 4'(rx_count);
    status[ST_TXCNT_LSB +: 4]      = 4'(tx_count);
  end

  always_comb begin
    bus_out = '0;
    if (io_oe && !io_we) begin
      if (is_status)     bus_out = status;
      else if (hold_vld) bus_out = rd_hold;
      else               bus_out = rx_head;
    end
  end

`ifdef IO_PORT_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) io_irq <= 1'b0;
    else     io_irq <= !rx_empty | tx_ovf | rx_udf;
  end
`endif

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port: stimulus pushes expected words into scoreboards,
// monitors compare CPU reads and device TX handshakes as they appear.
module tb_io_port;

  typedef struct {
    logic [15:0] val;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] io_addr;
  logic        io_oe;
  logic        io_we;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic [15:0] dev_tx_data;
  logic        dev_tx_valid;
  logic        dev_tx_ready;
  logic [15:0] dev_rx_data;
  logic        dev_rx_valid;
  logic        dev_rx_ready;
`ifdef IO_PORT_IRQ_EN
  logic        io_irq;
`endif

  int checks = 0;
  int errors = 0;
  exp_t rd_q[$];
  exp_t tx_q[$];

  io_port #(.word_width(16), .fifo_depth(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_addr      (io_addr),
    .io_oe        (io_oe),
    .io_we        (io_we),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .dev_tx_data  (dev_tx_data),
    .dev_tx_valid (dev_tx_valid),
    .dev_tx_ready (dev_tx_ready),
    .dev_rx_data  (dev_rx_data),
    .dev_rx_valid (dev_rx_valid),
    .dev_rx_ready (dev_rx_ready)
`ifdef IO_PORT_IRQ_EN
    ,
    .io_irq       (io_irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // CPU-read monitor: every cycle io_oe is high, bus_out must match the next expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && io_oe) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %h with no expectation", bus_out);
      end else begin
        e = rd_q.pop_front();
        if (bus_out !== e.val) begin
          errors++;
          $display("FAIL %s got %h want %h", e.tag, bus_out, e.val);
        end
      end
    end
  end

  // Device-TX monitor: each accepted handshake must carry the next expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dev_tx_valid && dev_tx_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %h with no expectation", dev_tx_data);
      end else begin
        e = tx_q.pop_front();
        if (dev_tx_data !== e.val) begin
          errors++;
          $display("FAIL %s got %h want %h", e.tag, dev_tx_data, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, want);
    end
  endtask

  task automatic cpu_write(input logic a, input logic [15:0] d);
    io_addr = {15'd0, a};
    bus_in  = d;
    io_we   = 1'b1;
    step();
    io_we   = 1'b0;
    step();
  endtask

  task automatic cpu_read(input logic a, input int n, input logic [15:0] want, input string tag);
    io_addr = {15'd0, a};
    for (int i = 0; i < n; i++) rd_q.push_back('{want, tag});
    io_oe = 1'b1;
    repeat (n) step();
    io_oe = 1'b0;
    step();
  endtask

  task automatic dev_push(input logic [15:0] d);
    dev_rx_data  = d;
    dev_rx_valid = 1'b1;
    step();
    dev_rx_valid = 1'b0;
  endtask

  task automatic tx_expect(input logic [15:0] d, input string tag);
    tx_q.push_back('{d, tag});
  endtask

  task automatic tx_drain(input int n);
    dev_tx_ready = 1'b1;
    repeat (n) step();
    dev_tx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; io_addr = '0; io_oe = 1'b0; io_we = 1'b0; bus_in = '0;
    dev_tx_ready = 1'b0; dev_rx_data = '0; dev_rx_valid = 1'b0;
    step();
    step();
    chk("rst_rx_ready", {15'd0, dev_rx_ready}, 16'd0);
    chk("rst_tx_valid", {15'd0, dev_tx_valid}, 16'd0);
    chk("rst_tx_data", dev_tx_data, 16'h0000);
    chk("rst_bus_out", bus_out, 16'h0000);
`ifdef IO_PORT_IRQ_EN
    chk("rst_irq", {15'd0, io_irq}, 16'd0);
`endif
    rst = 1'b0;
    step();
    chk("rx_ready_after_rst", {15'd0, dev_rx_ready}, 16'd1);
    cpu_read(1'b1, 1, 16'h0000, "status_after_reset");

    // Two TX words held back by the device, then released.
    cpu_write(1'b0, 16'hA5A5);
    cpu_write(1'b0, 16'h1234);
    cpu_read(1'b1, 1, 16'h2000, "status_tx2");
    chk("tx_head_a5a5", dev_tx_data, 16'hA5A5);
    chk("tx_valid_2", {15'd0, dev_tx_valid}, 16'd1);
    tx_expect(16'hA5A5, "tx_word0");
    tx_expect(16'h1234, "tx_word1");
    tx_drain(2);
    chk("tx_valid_drained", {15'd0, dev_tx_valid}, 16'd0);

    // Overflow: fifth write dropped, then write-1-to-clear.
    for (int i = 1; i <= 5; i++) cpu_write(1'b0, 16'(16'hC000 + i));
    cpu_read(1'b1, 1, 16'h4006, "status_tx_ovf");
    cpu_write(1'b1, 16'h0004);
    cpu_read(1'b1, 1, 16'h4002, "status_ovf_cleared");
    for (int i = 1; i <= 4; i++) tx_expect(16'(16'hC000 + i), "tx_ovf_drain");
    tx_drain(4);
    chk("tx_valid_after_ovf", {15'd0, dev_tx_valid}, 16'd0);

    // Full TX with a simultaneous device pop: push accepted, no overflow.
    for (int i = 1; i <= 4; i++) cpu_write(1'b0, 16'(16'hA000 + i));
    io_addr = '0; bus_in = 16'hA005; io_we = 1'b1; dev_tx_ready = 1'b1;
    tx_expect(16'hA001, "tx_full_pop");
    step();
    io_we = 1'b0; dev_tx_ready = 1'b0;
    step();
    cpu_read(1'b1, 1, 16'h4002, "status_full_push_pop");
    for (int i = 2; i <= 5; i++) tx_expect(16'(16'hA000 + i), "tx_full_pop_drain");
    tx_drain(4);

    // RX words; a read held three cycles pops once and keeps its value.
    dev_push(16'h00FF);
    dev_push(16'h0F0F);
    cpu_read(1'b1, 1, 16'h0201, "status_rx2");
    cpu_read(1'b0, 3, 16'h00FF, "rx_held_read");
    cpu_read(1'b1, 1, 16'h0101, "status_rx1");
    cpu_read(1'b0, 1, 16'h0F0F, "rx_second");
    cpu_read(1'b1, 1, 16'h0000, "status_rx_empty");

    // Underflow on empty read, then clear.
    cpu_read(1'b0, 1, 16'h0000, "rx_empty_read");
    cpu_read(1'b1, 1, 16'h0008, "status_rx_udf");
    cpu_write(1'b1, 16'h0008);
    cpu_read(1'b1, 1, 16'h0000, "status_udf_cleared");

    // RX full with device holding valid: one CPU pop admits exactly one word.
    for (int i = 1; i <= 4; i++) dev_push(16'(16'h0011 * i));
    chk("rx_ready_full", {15'd0, dev_rx_ready}, 16'd0);
    dev_rx_data = 16'h0055; dev_rx_valid = 1'b1;
    cpu_read(1'b0, 1, 16'h0011, "rx_full_pop");
    dev_rx_valid = 1'b0;
    chk("rx_ready_refull", {15'd0, dev_rx_ready}, 16'd0);
    cpu_read(1'b1, 1, 16'h0401, "status_rx_refull");
    cpu_read(1'b0, 1, 16'h0022, "rx_drain1");
    cpu_read(1'b0, 1, 16'h0033, "rx_drain2");
    cpu_read(1'b0, 1, 16'h0044, "rx_drain3");
    cpu_read(1'b0, 1, 16'h0055, "rx_drain4");
    cpu_read(1'b1, 1, 16'h0000, "status_rx_drained");

    // Empty RX, device push and CPU read in the same cycle: read is 0, push kept.
    io_addr = '0; io_oe = 1'b1; dev_rx_data = 16'h0066; dev_rx_valid = 1'b1;
    rd_q.push_back('{16'h0000, "rx_push_pop_empty"});
    step();
    io_oe = 1'b0; dev_rx_valid = 1'b0;
    step();
    cpu_read(1'b1, 1, 16'h0109, "status_push_pop_empty");
    cpu_write(1'b1, 16'h0008);
    cpu_read(1'b0, 1, 16'h0066, "rx_kept_word");

    // io_oe and io_we together: write happens, bus_out is 0, no RX pop.
    dev_push(16'h0077);
    io_addr = '0; bus_in = 16'h9999; io_oe = 1'b1; io_we = 1'b1;
    rd_q.push_back('{16'h0000, "oe_we_bus"});
    step();
    io_oe = 1'b0; io_we = 1'b0;
    step();
    cpu_read(1'b1, 1, 16'h1101, "status_oe_we");
    tx_expect(16'h9999, "tx_oe_we");
    tx_drain(1);
    cpu_read(1'b0, 1, 16'h0077, "rx_after_oe_we");

`ifdef IO_PORT_IRQ_EN
    dev_push(16'h0088);
    chk("irq_one_cycle", {15'd0, io_irq}, 16'd0);
    step();
    chk("irq_two_cycles", {15'd0, io_irq}, 16'd1);
    cpu_read(1'b0, 1, 16'h0088, "rx_irq_word");
    chk("irq_drained", {15'd0, io_irq}, 16'd0);
`endif

    // Reset with words in both FIFOs discards everything.
    cpu_write(1'b0, 16'hBEEF);
    dev_push(16'h0001);
    rst = 1'b1;
    step();
    chk("rst_mid_rx_ready", {15'd0, dev_rx_ready}, 16'd0);
    rst = 1'b0;
    chk("rst_mid_tx_valid", {15'd0, dev_tx_valid}, 16'd0);
    chk("rst_mid_tx_data", dev_tx_data, 16'h0000);
    step();
    cpu_read(1'b1, 1, 16'h0000, "status_after_mid_rst");

    step();
    chk("rd_q_leftover", 16'(rd_q.size()), 16'd0);
    chk("tx_q_leftover", 16'(tx_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
